// File: rtl/prog_run_ctrl.sv
// prog_run_ctrl: streams a program into the mini-MIPS instruction memory,
// pulses the core's start input, then times the run until done.
// Optional watchdog on the RUN phase: define PRC_TIMEOUT_EN.
module prog_run_ctrl #(
  parameter int IW             = 9,
  parameter int AW             = 8,
  parameter int START_CYCLES   = 1,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld_valid,
  input  logic [IW-1:0]    ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             run_req,
  output logic             im_we,
  output logic [AW-1:0]    im_addr,
  output logic [IW-1:0]    im_wdata,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             finished,
  output logic             timeout,
  output logic [AW:0]      prog_len,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_FIN} state_t;

  // Highest memory index; a word landing here always terminates the load.
  localparam logic [AW:0] LAST_IDX = {1'b0, {AW{1'b1}}};
  localparam logic [3:0]  ST_LAST  = 4'(START_CYCLES - 1);

  state_t      state, state_nxt;
  logic [AW:0] idx;
  logic [AW:0] cur_idx;
  logic [3:0]  st_cnt;
  logic        accept;
  logic        last_word;
  logic        wd_hit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and handshake/strobe outputs
  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    // A word accepted in IDLE begins a fresh program at index 0.
    cur_idx   = (state == S_IDLE) ? '0 : idx;
    last_word = ld_last || (cur_idx == LAST_IDX);
    case (state)
      S_IDLE: begin
        busy     = 1'b0;
        ld_ready = 1'b1;
        accept   = ld_valid;
        if (accept)       state_nxt = last_word ? S_START : S_LOAD;
        else if (run_req) state_nxt = S_START;
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        accept   = ld_valid;
        if (accept && last_word) state_nxt = S_START;
      end
      S_START: begin
        // Hold start off while the trailing memory write is still out.
        start = ~im_we;
        if (start && (st_cnt == ST_LAST)) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (done || wd_hit) state_nxt = S_FIN;
      end
      S_FIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Memory write pipeline, load bookkeeping, run status
  always_ff @(posedge clk) begin
    if (reset) begin
      im_we       <= 1'b0;
      im_addr     <= '0;
      im_wdata    <= '0;
      idx         <= '0;
      prog_len    <= '0;
      finished    <= 1'b0;
      cycle_count <= '0;
      st_cnt      <= '0;
    end else begin
      im_we <= accept;
      if (accept) begin
        im_addr  <= cur_idx[AW-1:0];
        im_wdata <= ld_data;
        idx      <= cur_idx + (AW+1)'(1);
        if (last_word) prog_len <= cur_idx + (AW+1)'(1);
      end
      if (state == S_IDLE && (accept || run_req)) begin
        finished    <= 1'b0;
        cycle_count <= '0;
      end
      if (state != S_START) st_cnt <= '0;
      else if (start)       st_cnt <= st_cnt + 4'd1;
      if (state == S_RUN) begin
        if (done || wd_hit) finished <= 1'b1;
        // The done cycle itself is not counted; the watchdog cycle is.
        if (!done && (cycle_count != {CNT_W{1'b1}}))
          cycle_count <= cycle_count + CNT_W'(1);
      end
    end
  end

`ifdef PRC_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign wd_hit  = (state == S_RUN) && (wd_cnt == WD_LAST);
  assign timeout = timeout_q;

  // Watchdog: counts RUN cycles; done in the same cycle takes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt <= (state == S_RUN) ? wd_cnt + WD_W'(1) : '0;
      if (state == S_IDLE && (accept || run_req)) timeout_q <= 1'b0;
      else if (wd_hit && !done)                   timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/prog_run_ctrl.md
Name: prog_run_ctrl

Overview:
- Host-side initiator for the 9-bit mini-MIPS `topLevel` core.
- Streams a program into instruction memory through that memory's write port, then drives the core's `start` input and waits for `done`.
- Reports completion, cycle count, and an optional watchdog timeout.
- Replaces the hierarchical backdoor loading of `instrMem1.Core[]` with real RTL, so programs can be loaded and run in both synthesis and simulation.

Parameters:
- IW, 9, instruction word width in bits.
- AW, 8, instruction memory address width; depth is 2**AW.
- START_CYCLES, 1, number of cycles `start` is held high per run (range 1..15).
- CNT_W, 16, width of the run cycle counter.
- TIMEOUT_CYCLES, 4096, watchdog limit in RUN cycles; used only with PRC_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  host has a program word on ld_data
- ld_data  in  IW  program word
- ld_last  in  1  marks the final word of the program
- ld_ready  out  1  controller can accept a word
- run_req  in  1  re-run the loaded program without reloading (IDLE only)
- im_we  out  1  instruction memory write enable
- im_addr  out  AW  instruction memory write address
- im_wdata  out  IW  instruction memory write data
- start  out  1  core start/reset request
- done  in  1  core completion flag (level)
- busy  out  1  controller is not in IDLE
- finished  out  1  sticky: last run has ended
- timeout  out  1  sticky: last run was ended by the watchdog
- prog_len  out  AW+1  number of words in the last load
- cycle_count  out  CNT_W  RUN cycles of the last run, saturating

Behaviour:
- One clock, `clk`. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0, except ld_ready = 1.
  - State = IDLE; word index = 0.
- States: IDLE, LOAD, START, RUN, FIN.
- IDLE:
  - ld_ready = 1.
  - An accepted word (ld_valid & ld_ready) goes to LOAD and clears finished, timeout, cycle_count, and the word index.
  - Else run_req = 1 goes to START and clears finished, timeout, and cycle_count.
  - If both occur in the same cycle, load wins.
- LOAD:
  - ld_ready = 1.
  - Each accepted word is written 1 cycle later: im_we = 1, im_addr = index, im_wdata = data. The index then increments.
  - Accepting ld_last goes to START; prog_len = index + 1.
  - The word at index 2**AW-1 is treated as last even if ld_last = 0; ld_ready drops after it.
  - ld_valid = 0 stalls the load; there is no timeout in LOAD.
- First IDLE word: it occupies index 0 and is written 1 cycle after acceptance, like any other word.
- START:
  - ld_ready = 0.
  - start = 1 for exactly START_CYCLES consecutive cycles.
  - The first start cycle immediately follows the last im_we cycle; no overlap with im_we.
  - done is ignored throughout START.
  - Then go to RUN.
- RUN:
  - start = 0.
  - cycle_count increments by 1 each cycle and saturates at all-ones.
  - done = 1 in RUN goes to FIN. The done cycle itself is not counted.
- FIN:
  - finished = 1 (registered, visible the cycle after done is sampled).
  - Return to IDLE next cycle.
- busy = 1 in LOAD, START, RUN, and FIN.
- run_req outside IDLE is ignored; there is no queuing.
- Reset mid-operation:
  - Returns to IDLE at that edge.
  - im_we and start drop at the same edge; a pending write is discarded.
  - prog_len resets to 0.
- Instruction memory is never written outside LOAD or the single trailing write cycle.

Optional Feature:
- Macro: PRC_TIMEOUT_EN.
- Defined:
  - A watchdog counts RUN cycles.
  - When it reaches TIMEOUT_CYCLES without done: timeout = 1, finished = 1, start stays 0, go to FIN.
  - cycle_count = TIMEOUT_CYCLES in that case.
  - done and the timeout in the same cycle: done wins, timeout = 0.
- Not defined:
  - timeout is tied to 0 and there is no watchdog logic.
  - RUN waits on done indefinitely.

Test Plan:
- Load 8 words (0x082, 0x092, 0x16D, 0x0A4, 0x144, 0x151, 0x0A2, 0x0B0) with ld_last on word 7 → im_we pulses at addr 0..7 with matching data; prog_len = 8; start high 1 cycle, right after the addr-7 write; core raises done 20 cycles later → cycle_count = 20, finished = 1, busy = 0 next cycle.
- After the test above, run_req pulse with no load → no im_we, start pulse, done after 5 RUN cycles → cycle_count = 5, prog_len still 8.
- ld_valid toggling 1,0,1,0 across 3 words → exactly 3 writes at addr 0,1,2 with no gaps in addressing; done held high during START is ignored; run ends only on done in RUN.
- Stream 300 words with no ld_last → 256 writes (addr 0..255); ld_ready = 0 after word 255; prog_len = 256; start follows.
- Assert reset during RUN and during mid-LOAD → next cycle all outputs at reset values, ld_ready = 1; a later load starts at addr 0.
- PRC_TIMEOUT_EN with TIMEOUT_CYCLES = 100 and done never asserted → timeout = 1, finished = 1, cycle_count = 100. Without the macro, the same stimulus leaves busy = 1 after 10000 cycles.
